pc_source_ctrl: RTL and testbench
=================================

Name: pc_source_ctrl

Overview:
Multicycle PC-update sequencer for the MIPS datapath. It drives the 3-bit select of the 5-input PC-source mux and the PC/EPC write enables. It orders fetch, branch/jump resolution and exception entry with fixed priorities. It sits between the main control FSM and the PC register.

Parameters:
CAUSE_W, 2, width of exception cause code
PEND_CLR_ON_TAKE, 1, 1 = pending IRQ cleared when exception entered; 0 = cleared only by irq_ack

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
mem_ready  in  1  instruction memory has data this cycle
is_beq  in  1  decoded BEQ
is_bne  in  1  decoded BNE
is_j  in  1  decoded J/JAL
is_jr  in  1  decoded JR
illegal_op  in  1  undefined opcode/funct (valid in DECODE)
alu_zero  in  1  ALU zero flag (valid in EXECUTE)
alu_ovf  in  1  signed overflow (valid in EXECUTE)
instr_done  in  1  main control: instruction write-back finished
irq  in  1  external interrupt request, level
irq_ack  in  1  software clears pending IRQ
pc_sel  out  3  PC-source mux select
pc_write  out  1  PC register load enable
epc_write  out  1  EPC load enable (captures current PC)
cause  out  CAUSE_W  registered cause of last exception
state_o  out  3  current state, for debug

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n); all flops clear immediately on rst_n=0.
- Reset values: state=FETCH, pc_sel=0, pc_write=0, epc_write=0, cause=0, irq_pend=0.
- pc_sel encoding: 0=PC+4 (ALU result), 1=branch target (ALUOut), 2=jump target {PC[31:28],imm26,2'b00}, 3=register rs (JR), 4=exception vector. Values 5-7 are never driven.
- pc_sel, pc_write and epc_write are registered. They are asserted during the single cycle after the decision edge and are 0 in all other cycles.
- irq_pend: set on any cycle with irq=1. Cleared on irq_ack. Also cleared when EXCEPT is entered with cause IRQ if PEND_CLR_ON_TAKE=1. If set and clear occur in the same cycle, set wins.
- States:
  - FETCH: if irq_pend, go to EXCEPT with cause=3; no fetch update. Else if mem_ready, pulse pc_write with pc_sel=0 and go to DECODE. Else hold.
  - DECODE: latch is_beq/is_bne/is_j/is_jr into the class register. If illegal_op, go to EXCEPT with cause=1. Else go to EXECUTE. A pending IRQ does not preempt DECODE.
  - EXECUTE (exactly 1 cycle):
    - Priority: alu_ovf > jr > j > taken branch > none.
    - alu_ovf: go to EXCEPT, cause=2, no PC update.
    - jr: pc_sel=3 with pc_write pulse.
    - j: pc_sel=2 with pc_write pulse.
    - Taken branch = (beq & alu_zero) | (bne & ~alu_zero): pc_sel=1 with pc_write pulse.
    - Next state is COMPLETE.
  - COMPLETE: wait for instr_done=1, then go to FETCH. If instr_done is already high on entry, leave after 1 cycle.
  - EXCEPT (1 cycle): pulse pc_write and epc_write with pc_sel=4, then go to FETCH. The cause register updates on entry.
- Simultaneous events:
  - illegal_op plus pending IRQ in DECODE: illegal wins; the IRQ stays pending and is taken at the next FETCH.
  - More than one of is_beq/is_bne/is_j/is_jr high: resolved by the EXECUTE priority above.
- Latency:
  - Sequential instruction: PC+4 written 1 cycle after mem_ready in FETCH.
  - Branch/jump target: written 3 cycles after the fetch edge.
- Reset mid-operation: immediate return to FETCH, outputs cleared, and the pending IRQ is lost.

Optional Feature:
PC_PERF_CNT_EN. When defined, adds output ports retired_cnt[31:0] and taken_cnt[31:0]:
- retired_cnt increments on each COMPLETE to FETCH transition.
- taken_cnt increments on each EXECUTE cycle that pulses pc_write.
- Both wrap at 2^32 and clear on reset.

When undefined, neither the ports nor the counters exist, and behaviour is otherwise identical.

Decomposition:
- Shared package pc_ctrl_pkg holds:
  - pc_sel constants PCSEL_SEQ=0, PCSEL_BR=1, PCSEL_JMP=2, PCSEL_REG=3, PCSEL_EXC=4.
  - State encoding FETCH=0, DECODE=1, EXECUTE=2, COMPLETE=3, EXCEPT=4.
  - Cause codes CAUSE_NONE=0, CAUSE_ILL=1, CAUSE_OVF=2, CAUSE_IRQ=3.
- One natural sub-module, pc_irq_pending: the irq_pend flag with its set/clear priority.

Test Plan:
- Reset asserted mid-EXECUTE -> next sample shows state_o=0 and pc_write=0, epc_write=0, pc_sel=0, cause=0.
- mem_ready=1 in FETCH, no control op, instr_done=1 -> pc_write pulses once with pc_sel=0; sequence FETCH, DECODE, EXECUTE, COMPLETE, FETCH spans 4 cycles.
- is_beq=1, alu_zero=1 -> EXECUTE emits pc_sel=1, pc_write=1. Repeat with alu_zero=0 -> no pc_write in EXECUTE.
- is_jr=1 and is_j=1 together -> pc_sel=3 only.
- alu_ovf=1 with is_beq=1, alu_zero=1 -> no branch write; EXCEPT pulses pc_write and epc_write with pc_sel=4; cause=2.
- irq pulse during DECODE together with illegal_op=1 -> cause=1 exception first; the next FETCH enters EXCEPT with cause=3 and no fetch write.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// Shared encodings for the PC-update sequencer: mux selects, states, cause codes,
// the latched instruction class and the branch-taken helper.
package pc_ctrl_pkg;

    localparam logic [2:0] PCSEL_SEQ = 3'd0;
    localparam logic [2:0] PCSEL_BR  = 3'd1;
    localparam logic [2:0] PCSEL_JMP = 3'd2;
    localparam logic [2:0] PCSEL_REG = 3'd3;
    localparam logic [2:0] PCSEL_EXC = 3'd4;

    localparam int unsigned CAUSE_NONE = 0;
    localparam int unsigned CAUSE_ILL  = 1;
    localparam int unsigned CAUSE_OVF  = 2;
    localparam int unsigned CAUSE_IRQ  = 3;

    typedef enum logic [2:0] {
        FETCH    = 3'd0,
        DECODE   = 3'd1,
        EXECUTE  = 3'd2,
        COMPLETE = 3'd3,
        EXCEPT   = 3'd4
    } pc_state_t;

    typedef struct packed {
        logic beq;
        logic bne;
        logic j;
        logic jr;
    } op_class_t;

    function automatic logic branch_taken(input op_class_t cls, input logic zero);
        return (cls.beq & zero) | (cls.bne & ~zero);
    endfunction

endpackage

// File: rtl/pc_irq_pending.sv
// Pending-interrupt flag: set by any irq cycle, cleared by ack or exception take.
// A set in the same cycle as a clear keeps the flag set.
module pc_irq_pending (
    input  logic clk,
    input  logic rst_n,
    input  logic irq,
    input  logic irq_ack,
    input  logic take,
    output logic pend
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 1'b0;
        end else if (irq) begin
            pend <= 1'b1;
        end else if (irq_ack || take) begin
            pend <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_source_ctrl.sv
// Multicycle PC-source sequencer: registered pc_sel / pc_write / epc_write and cause.
// Optional PC_PERF_CNT_EN adds retired_cnt and taken_cnt performance counters.
//
// state    | meaning
// FETCH    | wait for mem_ready (PC+4 write) or take a pending IRQ
// DECODE   | latch instruction class, trap illegal opcodes
// EXECUTE  | resolve overflow / jr / j / branch, single cycle
// COMPLETE | wait for instr_done from main control
// EXCEPT   | load exception vector into PC, current PC into EPC
module pc_source_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int CAUSE_W          = 2,
    parameter int PEND_CLR_ON_TAKE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mem_ready,
    input  logic               is_beq,
    input  logic               is_bne,
    input  logic               is_j,
    input  logic               is_jr,
    input  logic               illegal_op,
    input  logic               alu_zero,
    input  logic               alu_ovf,
    input  logic               instr_done,
    input  logic               irq,
    input  logic               irq_ack,
    output logic [2:0]         pc_sel,
    output logic               pc_write,
    output logic               epc_write,
    output logic [CAUSE_W-1:0] cause,
    output logic [2:0]         state_o
`ifdef PC_PERF_CNT_EN
    ,
    output logic [31:0]        retired_cnt,
    output logic [31:0]        taken_cnt
`endif
);

    pc_state_t          state, state_nxt;
    op_class_t          op_class, op_class_nxt;
    logic [2:0]         pc_sel_nxt;
    logic               pc_write_nxt, epc_write_nxt;
    logic [CAUSE_W-1:0] cause_nxt;
    logic               irq_pend, irq_take, enter_exc;

    pc_irq_pending u_irq_pending (
        .clk     (clk),
        .rst_n   (rst_n),
        .irq     (irq),
        .irq_ack (irq_ack),
        .take    (irq_take),
        .pend    (irq_pend)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            op_class  <= '0;
            pc_sel    <= PCSEL_SEQ;
            pc_write  <= 1'b0;
            epc_write <= 1'b0;
            cause     <= '0;
        end else begin
            state     <= state_nxt;
            op_class  <= op_class_nxt;
            pc_sel    <= pc_sel_nxt;
            pc_write  <= pc_write_nxt;
            epc_write <= epc_write_nxt;
            cause     <= cause_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        op_class_nxt  = op_class;
        pc_sel_nxt    = PCSEL_SEQ;
        pc_write_nxt  = 1'b0;
        epc_write_nxt = 1'b0;
        cause_nxt     = cause;
        irq_take      = 1'b0;
        enter_exc     = 1'b0;
        case (state)
            FETCH: begin
                if (irq_pend) begin
                    enter_exc = 1'b1;
                    cause_nxt = CAUSE_W'(CAUSE_IRQ);
                    irq_take  = (PEND_CLR_ON_TAKE != 0);
                end else if (mem_ready) begin
                    state_nxt    = DECODE;
                    pc_write_nxt = 1'b1;
                end
            end
            DECODE: begin
                op_class_nxt = '{beq: is_beq, bne: is_bne, j: is_j, jr: is_jr};
                if (illegal_op) begin
                    enter_exc = 1'b1;
                    cause_nxt = CAUSE_W'(CAUSE_ILL);
                end else begin
                    state_nxt = EXECUTE;
                end
            end
            EXECUTE: begin
                state_nxt = COMPLETE;
                if (alu_ovf) begin
                    enter_exc = 1'b1;
                    cause_nxt = CAUSE_W'(CAUSE_OVF);
                end else if (op_class.jr) begin
                    pc_sel_nxt   = PCSEL_REG;
                    pc_write_nxt = 1'b1;
                end else if (op_class.j) begin
                    pc_sel_nxt   = PCSEL_JMP;
                    pc_write_nxt = 1'b1;
                end else if (branch_taken(op_class, alu_zero)) begin
                    pc_sel_nxt   = PCSEL_BR;
                    pc_write_nxt = 1'b1;
                end
            end
            COMPLETE: begin
                if (instr_done) state_nxt = FETCH;
            end
            EXCEPT: begin
                state_nxt = FETCH;
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
        // Exception pulses are registered on entry so they are visible during EXCEPT.
        if (enter_exc) begin
            state_nxt     = EXCEPT;
            pc_sel_nxt    = PCSEL_EXC;
            pc_write_nxt  = 1'b1;
            epc_write_nxt = 1'b1;
        end
    end

    assign state_o = state;

`ifdef PC_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt <= '0;
            taken_cnt   <= '0;
        end else begin
            if (state == COMPLETE && instr_done) retired_cnt <= retired_cnt + 32'd1;
            if (state == EXECUTE && pc_write_nxt && !alu_ovf) taken_cnt <= taken_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_source_ctrl.sv
// Directed bench for pc_source_ctrl; expected values are hand-computed per step.
module tb_pc_source_ctrl;

    logic       clk, rst_n;
    logic       mem_ready, is_beq, is_bne, is_j, is_jr, illegal_op;
    logic       alu_zero, alu_ovf, instr_done, irq, irq_ack;
    logic [2:0] pc_sel;
    logic       pc_write, epc_write;
    logic [1:0] cause;
    logic [2:0] state_o;
`ifdef PC_PERF_CNT_EN
    logic [31:0] retired_cnt, taken_cnt;
`endif

    int total = 0;
    int bad   = 0;

    pc_source_ctrl #(.CAUSE_W(2), .PEND_CLR_ON_TAKE(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_ready  (mem_ready),
        .is_beq     (is_beq),
        .is_bne     (is_bne),
        .is_j       (is_j),
        .is_jr      (is_jr),
        .illegal_op (illegal_op),
        .alu_zero   (alu_zero),
        .alu_ovf    (alu_ovf),
        .instr_done (instr_done),
        .irq        (irq),
        .irq_ack    (irq_ack),
        .pc_sel     (pc_sel),
        .pc_write   (pc_write),
        .epc_write  (epc_write),
        .cause      (cause),
        .state_o    (state_o)
`ifdef PC_PERF_CNT_EN
        ,
        .retired_cnt(retired_cnt),
        .taken_cnt  (taken_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // state, pc_write, pc_sel, epc_write as seen in the current cycle
    task automatic expect_out(input string tag, input int st, input int pw, input int ps, input int ew);
        chk({tag, ".state"},     32'(state_o),   32'(st));
        chk({tag, ".pc_write"},  32'(pc_write),  32'(pw));
        chk({tag, ".pc_sel"},    32'(pc_sel),    32'(ps));
        chk({tag, ".epc_write"}, 32'(epc_write), 32'(ew));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ops();
        is_beq = 0; is_bne = 0; is_j = 0; is_jr = 0; illegal_op = 0;
        alu_zero = 0; alu_ovf = 0; irq = 0; irq_ack = 0; mem_ready = 0;
    endtask

    // From FETCH: fetch, decode with the given class, execute with the given flags.
    // Leaves the DUT sampled in the cycle after EXECUTE.
    task automatic run_op(input logic beq, input logic bne, input logic j, input logic jr,
                          input logic zero, input logic ovf);
        mem_ready = 1; tick();
        mem_ready = 0; is_beq = beq; is_bne = bne; is_j = j; is_jr = jr; tick();
        is_beq = 0; is_bne = 0; is_j = 0; is_jr = 0; alu_zero = zero; alu_ovf = ovf; tick();
        alu_zero = 0; alu_ovf = 0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0; instr_done = 0;
        clear_ops();
        #12;
        expect_out("reset", 0, 0, 0, 0);
        chk("reset.cause", 32'(cause), 0);
        #5 rst_n = 1;
        tick();
        expect_out("idle", 0, 0, 0, 0);

        // sequential instruction: FETCH->DECODE->EXECUTE->COMPLETE->FETCH in 4 cycles
        instr_done = 1; mem_ready = 1; tick();
        expect_out("seq.dec", 1, 1, 0, 0);
        mem_ready = 0; tick();
        expect_out("seq.exe", 2, 0, 0, 0);
        tick();
        expect_out("seq.cmp", 3, 0, 0, 0);
        tick();
        expect_out("seq.fet", 0, 0, 0, 0);

        run_op(1, 0, 0, 0, 1, 0);
        expect_out("beq_taken", 3, 1, 1, 0);
        tick();
        expect_out("beq_taken.fet", 0, 0, 0, 0);

        run_op(1, 0, 0, 0, 0, 0);
        expect_out("beq_not", 3, 0, 0, 0);
        tick();

        run_op(0, 1, 0, 0, 0, 0);
        expect_out("bne_taken", 3, 1, 1, 0);
        tick();

        run_op(0, 0, 1, 1, 0, 0);
        expect_out("jr_and_j", 3, 1, 3, 0);
        tick();

        run_op(1, 0, 1, 0, 1, 0);
        expect_out("j_over_beq", 3, 1, 2, 0);
        tick();

        // overflow beats a taken branch
        run_op(1, 0, 0, 0, 1, 1);
        expect_out("ovf", 4, 1, 4, 1);
        chk("ovf.cause", 32'(cause), 2);
        tick();
        expect_out("ovf.fet", 0, 0, 0, 0);
        chk("ovf.cause_hold", 32'(cause), 2);

        // COMPLETE waits for instr_done
        instr_done = 0;
        run_op(0, 0, 0, 0, 0, 0);
        tick();
        expect_out("cmp.wait", 3, 0, 0, 0);
        instr_done = 1; tick();
        expect_out("cmp.leave", 0, 0, 0, 0);

        // illegal_op + irq in DECODE: illegal first, IRQ at next FETCH without fetch write
        mem_ready = 1; tick();
        mem_ready = 0; illegal_op = 1; irq = 1; tick();
        expect_out("ill", 4, 1, 4, 1);
        chk("ill.cause", 32'(cause), 1);
        illegal_op = 0; irq = 0; tick();
        expect_out("ill.fet", 0, 0, 0, 0);
        mem_ready = 1; tick();
        expect_out("irq", 4, 1, 4, 1);
        chk("irq.cause", 32'(cause), 3);
        mem_ready = 0; tick();
        expect_out("irq.fet", 0, 0, 0, 0);
        tick();
        expect_out("irq.cleared", 0, 0, 0, 0);

        // irq_ack clears the pending flag before the next FETCH
        mem_ready = 1; tick();
        mem_ready = 0; irq = 1; tick();
        expect_out("ack.exe", 2, 0, 0, 0);
        irq = 0; irq_ack = 1; tick();
        irq_ack = 0; tick();
        tick();
        expect_out("ack.no_exc", 0, 0, 0, 0);

        // irq and irq_ack together: set wins
        mem_ready = 1; tick();
        mem_ready = 0; irq = 1; irq_ack = 1; tick();
        irq = 0; irq_ack = 0; tick();
        tick();
        tick();
        expect_out("setwins", 4, 1, 4, 1);
        chk("setwins.cause", 32'(cause), 3);
        tick();

        // reset mid-EXECUTE with an IRQ pending: everything clears and the IRQ is lost
        mem_ready = 1; tick();
        mem_ready = 0; irq = 1; tick();
        irq = 0;
        expect_out("rst.pre", 2, 0, 0, 0);
        #2 rst_n = 0;
        #1;
        expect_out("rst.mid", 0, 0, 0, 0);
        chk("rst.cause", 32'(cause), 0);
        #3 rst_n = 1;
        tick();
        tick();
        expect_out("rst.pend_lost", 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
